// File: rtl/sal_bank_ctrl_if.sv
// Bundles used by the per-bank controller: timing values, incoming
// requests and the command/grant link to the cross-bank scheduler.

interface TIMING_IF;
    logic [7:0] t_rcd_m1;
    logic [7:0] t_ras_m1;
    logic [7:0] t_rtp_m1;
    logic [7:0] t_wtp_m1;
    logic [7:0] t_rp_m1;
    logic [7:0] t_rfc_m1;
    logic [7:0] row_open_cnt;

    modport MON (input t_rcd_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rp_m1, t_rfc_m1, row_open_cnt);
    modport DRV (output t_rcd_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rp_m1, t_rfc_m1, row_open_cnt);
endinterface

interface REQ_IF #(
    parameter int RA_W  = 16,
    parameter int CA_W  = 10,
    parameter int ID_W  = 4,
    parameter int LEN_W = 4
);
    logic             valid;
    logic             ready;
    logic             wr;
    logic [ID_W-1:0]  id;
    logic [RA_W-1:0]  ra;
    logic [CA_W-1:0]  ca;
    logic [LEN_W-1:0] len;

    modport SRC (output valid, wr, id, ra, ca, len, input ready);
    modport DST (input valid, wr, id, ra, ca, len, output ready);
endinterface

interface SCHED_IF #(
    parameter int DRAM_BA_WIDTH = 3,
    parameter int RA_W          = 16,
    parameter int CA_W          = 10,
    parameter int ID_W          = 4,
    parameter int LEN_W         = 4
);
    logic                     act_req, rd_req, wr_req, pre_req, ref_req;
    logic                     act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [DRAM_BA_WIDTH-1:0] ba;
    logic [RA_W-1:0]          ra;
    logic [CA_W-1:0]          ca;
    logic [ID_W-1:0]          id;
    logic [LEN_W-1:0]         len;

    modport SRC (output act_req, rd_req, wr_req, pre_req, ref_req, ba, ra, ca, id, len,
                 input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt);
    modport DST (input  act_req, rd_req, wr_req, pre_req, ref_req, ba, ra, ca, id, len,
                 output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt);
endinterface

// File: rtl/sal_bank_ctrl.sv
// Single-bank DRAM controller: one-entry request buffer, open/closed row
// tracking, intra-bank timing counters and level command requests toward
// the cross-bank scheduler.

module sal_bank_ctrl #(
    parameter int                       DRAM_BA_WIDTH = 3,
    parameter logic [DRAM_BA_WIDTH-1:0] BK_ID         = '0,
    parameter int                       RA_W          = 16,
    parameter int                       CA_W          = 10,
    parameter int                       ID_W          = 4,
    parameter int                       LEN_W         = 4
) (
    input  logic  clk,
    input  logic  rst,
    TIMING_IF.MON timing_if,
    REQ_IF.DST    req_if,
    SCHED_IF.SRC  sched_if,
    input  logic  ref_req_i,
    output logic  ref_done_o
);
    localparam logic [1:0] ST_CLOSED  = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_PRECHG  = 2'd2;
    localparam logic [1:0] ST_REFRESH = 2'd3;

    // counter slots: 0 rcd, 1 ras, 2 rtp, 3 wtp, 4 rp, 5 rfc
    localparam int N_CNT = 6;

    logic [1:0]             state_reg, state_next;
    logic                   buf_v_reg, buf_wr_reg;
    logic [ID_W-1:0]        buf_id_reg;
    logic [RA_W-1:0]        buf_ra_reg, open_row_reg;
    logic [CA_W-1:0]        buf_ca_reg;
    logic [LEN_W-1:0]       buf_len_reg;
    logic [7:0]             idle_reg;
    logic [N_CNT-1:0][7:0]  cnt_val, cnt_init;
    logic [N_CNT-1:0]       cnt_load;

    logic act_req, rd_req, wr_req, pre_req, ref_req;
    logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
    logic hit, miss, idle_exp, close_cond, pre_ok;

    assign hit        = buf_v_reg && (buf_ra_reg == open_row_reg);
    assign miss       = buf_v_reg && (buf_ra_reg != open_row_reg);
    // The idle timer only runs with an empty buffer, so expiry is gated the same way.
    assign idle_exp   = !buf_v_reg && (idle_reg >= timing_if.row_open_cnt);
    assign close_cond = ref_req_i || miss || idle_exp;
    assign pre_ok     = (cnt_val[1] == 8'd0) && (cnt_val[2] == 8'd0) && (cnt_val[3] == 8'd0);

    // Command requests decoded from registered state; at most one is raised.
    always_comb begin
        act_req = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        pre_req = 1'b0;
        ref_req = 1'b0;
        case (state_reg)
            ST_CLOSED: begin
                if (ref_req_i)      ref_req = 1'b1;
                else if (buf_v_reg) act_req = 1'b1;
            end
            ST_OPEN: begin
                if (close_cond) begin
                    pre_req = pre_ok;
                end else if (hit && (cnt_val[0] == 8'd0)) begin
                    wr_req = buf_wr_reg;
                    rd_req = !buf_wr_reg;
                end
            end
            default: ;
        endcase
    end

    // A grant only counts when its own request is up.
    assign act_fire = act_req && sched_if.act_gnt;
    assign rd_fire  = rd_req  && sched_if.rd_gnt;
    assign wr_fire  = wr_req  && sched_if.wr_gnt;
    assign pre_fire = pre_req && sched_if.pre_gnt;
    assign ref_fire = ref_req && sched_if.ref_gnt;

    assign cnt_load = {ref_fire, pre_fire, wr_fire, rd_fire, act_fire, act_fire};
    assign cnt_init = {timing_if.t_rfc_m1, timing_if.t_rp_m1, timing_if.t_wtp_m1,
                       timing_if.t_rtp_m1, timing_if.t_ras_m1, timing_if.t_rcd_m1};

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic [7:0] cnt_reg;
            // Load on the owning grant, then count down and hold at zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                 cnt_reg <= '0;
                else if (cnt_load[gi])   cnt_reg <= cnt_init[gi];
                else if (cnt_reg != '0)  cnt_reg <= cnt_reg - 8'd1;
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    // Bank state transitions. PRECHG is left one cycle before rp reaches zero
    // so the next ACT/REF can be requested exactly t_rp_m1 + 1 cycles after PRE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_CLOSED: begin
                if (ref_fire)      state_next = ST_REFRESH;
                else if (act_fire) state_next = ST_OPEN;
            end
            ST_OPEN: begin
                if (pre_fire) state_next = (timing_if.t_rp_m1 == 8'd0) ? ST_CLOSED : ST_PRECHG;
            end
            ST_PRECHG: begin
                if (cnt_val[4] <= 8'd1) state_next = ST_CLOSED;
            end
            ST_REFRESH: begin
                if (cnt_val[5] == 8'd0) state_next = ST_CLOSED;
            end
            default: state_next = ST_CLOSED;
        endcase
    end

    // State register and the row latched by the ACT grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_CLOSED;
            open_row_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (act_fire) open_row_reg <= buf_ra_reg;
        end
    end

    // Single-entry request buffer: capture when empty, release on RD/WR grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_v_reg   <= 1'b0;
            buf_wr_reg  <= 1'b0;
            buf_id_reg  <= '0;
            buf_ra_reg  <= '0;
            buf_ca_reg  <= '0;
            buf_len_reg <= '0;
        end else if (req_if.valid && !buf_v_reg) begin
            buf_v_reg   <= 1'b1;
            buf_wr_reg  <= req_if.wr;
            buf_id_reg  <= req_if.id;
            buf_ra_reg  <= req_if.ra;
            buf_ca_reg  <= req_if.ca;
            buf_len_reg <= req_if.len;
        end else if (rd_fire || wr_fire) begin
            buf_v_reg <= 1'b0;
        end
    end

    // Row idle timer: counts empty-buffer cycles in OPEN, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_reg <= '0;
        end else if ((state_reg != ST_OPEN) || act_fire || rd_fire || wr_fire || buf_v_reg) begin
            idle_reg <= '0;
        end else if (idle_reg < timing_if.row_open_cnt) begin
            idle_reg <= idle_reg + 8'd1;
        end
    end

    assign req_if.ready     = !buf_v_reg;
    assign ref_done_o       = (state_reg == ST_REFRESH) && (cnt_val[5] == 8'd0);

    assign sched_if.act_req = act_req;
    assign sched_if.rd_req  = rd_req;
    assign sched_if.wr_req  = wr_req;
    assign sched_if.pre_req = pre_req;
    assign sched_if.ref_req = ref_req;
    assign sched_if.ba      = BK_ID;
    assign sched_if.ra      = buf_ra_reg;
    assign sched_if.ca      = buf_ca_reg;
    assign sched_if.id      = buf_id_reg;
    assign sched_if.len     = buf_len_reg;
endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Bench for sal_bank_ctrl: table of requests checked through a scoreboard
// by an auto-granting scheduler model, plus idle-timeout, refresh,
// withheld-grant and asynchronous-reset sequences.

module tb_sal_bank_ctrl;
    localparam logic [2:0] BK = 3'd5;
    localparam int T_RCD = 3;
    localparam int T_RAS = 9;
    localparam int T_RTP = 2;
    localparam int T_WTP = 7;
    localparam int T_RP  = 4;
    localparam int T_RFC = 6;
    localparam int ROC_MAIN = 20;
    localparam int ROC_IDLE = 5;

    typedef struct packed {
        logic        wr;
        logic [15:0] ra;
        logic [9:0]  ca;
        logic [3:0]  id;
        logic [3:0]  len;
        logic        need_act;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ref_req_i = 1'b0;
    logic ref_done_o;
    always #5 clk = ~clk;

    TIMING_IF tim ();
    REQ_IF    req ();
    SCHED_IF #(.DRAM_BA_WIDTH(3)) sch ();

    sal_bank_ctrl #(.DRAM_BA_WIDTH(3), .BK_ID(BK)) dut (
        .clk        (clk),
        .rst        (rst),
        .timing_if  (tim),
        .req_if     (req),
        .sched_if   (sch),
        .ref_req_i  (ref_req_i),
        .ref_done_o (ref_done_o)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    txn_t sb [$];
    logic mask_act = 1'b0, mask_rd = 1'b0, mask_pre = 1'b0, spur_rd = 1'b0;
    int   last_act = -1000, last_rd = -1000, last_wr = -1000, last_pre = -1000, last_ref = -1000;
    logic act_seen = 1'b0, pre_pend = 1'b0, ready_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_tests++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cyc %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scheduler model and scoreboard: grants whatever is requested unless
    // masked, pops the expected command on every RD/WR grant.
    always @(negedge clk) begin
        txn_t e;
        if (rst) begin
            sch.act_gnt = 1'b0; sch.rd_gnt = 1'b0; sch.wr_gnt = 1'b0;
            sch.pre_gnt = 1'b0; sch.ref_gnt = 1'b0;
            act_seen = 1'b0; pre_pend = 1'b0; ready_chk = 1'b0;
        end else begin
            check("req_onehot", 32'($countones({sch.act_req, sch.rd_req, sch.wr_req,
                                                sch.pre_req, sch.ref_req}) <= 1), 32'd1);
            if (ready_chk) check("ready_after_gnt", 32'(req.ready), 32'd1);
            ready_chk = 1'b0;
            sch.act_gnt = sch.act_req && !mask_act;
            sch.rd_gnt  = (sch.rd_req && !mask_rd) || spur_rd;
            sch.wr_gnt  = sch.wr_req;
            sch.pre_gnt = sch.pre_req && !mask_pre;
            sch.ref_gnt = sch.ref_req;
            if (sch.act_req && sch.act_gnt) begin
                if (sb.size() == 0) check("act_unexpected", 32'd1, 32'd0);
                else                check("act_ra", 32'(sch.ra), 32'(sb[0].ra));
                check("act_ba", 32'(sch.ba), 32'(BK));
                if (pre_pend) check("trp_gap", 32'(cyc - last_pre), 32'(T_RP + 1));
                $display("[TB] cyc=%0d ACT ra=%0h", cyc, sch.ra);
                pre_pend = 1'b0;
                act_seen = 1'b1;
                last_act = cyc;
            end
            if ((sch.rd_req && sch.rd_gnt) || (sch.wr_req && sch.wr_gnt)) begin
                if (sb.size() == 0) begin
                    check("cmd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] cyc=%0d %s ra=%0h ca=%0h id=%0h len=%0h",
                             cyc, sch.wr_req ? "WR" : "RD", sch.ra, sch.ca, sch.id, sch.len);
                    check("cmd_wr", 32'(sch.wr_req), 32'(e.wr));
                    check("cmd_ca", 32'(sch.ca), 32'(e.ca));
                    check("cmd_id", 32'(sch.id), 32'(e.id));
                    check("cmd_len", 32'(sch.len), 32'(e.len));
                    check("cmd_need_act", 32'(act_seen), 32'(e.need_act));
                    if (act_seen) check("trcd_gap", 32'(cyc - last_act), 32'(T_RCD + 1));
                end
                if (sch.wr_req) last_wr = cyc;
                else            last_rd = cyc;
                act_seen  = 1'b0;
                ready_chk = 1'b1;
            end
            if (sch.pre_req && sch.pre_gnt) begin
                $display("[TB] cyc=%0d PRE", cyc);
                check("pre_tras", 32'((cyc - last_act) >= T_RAS + 1), 32'd1);
                check("pre_trtp", 32'((cyc - last_rd) >= T_RTP + 1), 32'd1);
                check("pre_twtp", 32'((cyc - last_wr) >= T_WTP + 1), 32'd1);
                pre_pend = (sb.size() != 0) && !ref_req_i;
                last_pre = cyc;
            end
            if (sch.ref_req && sch.ref_gnt) begin
                $display("[TB] cyc=%0d REF", cyc);
                last_ref = cyc;
            end
        end
    end

    task automatic send(input txn_t t);
        int n = 0;
        while (req.ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_ready_timeout", 32'd0, 32'd1);
        req.valid = 1'b1;
        req.wr    = t.wr;
        req.ra    = t.ra;
        req.ca    = t.ca;
        req.id    = t.id;
        req.len   = t.len;
        sb.push_back(t);
        tick();
        req.valid = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t vecs [8];
        txn_t t;
        int   g, a, p, expd, x, n;

        vecs[0] = '{wr:1'b0, ra:16'h0012, ca:10'h004, id:4'h1, len:4'h3, need_act:1'b1};
        vecs[1] = '{wr:1'b1, ra:16'h0012, ca:10'h0a0, id:4'h2, len:4'h1, need_act:1'b0};
        vecs[2] = '{wr:1'b0, ra:16'h0034, ca:10'h155, id:4'h3, len:4'h7, need_act:1'b1};
        vecs[3] = '{wr:1'b0, ra:16'h0034, ca:10'h2aa, id:4'h4, len:4'h0, need_act:1'b0};
        vecs[4] = '{wr:1'b1, ra:16'h0056, ca:10'h3ff, id:4'h5, len:4'hf, need_act:1'b1};
        vecs[5] = '{wr:1'b1, ra:16'h0056, ca:10'h001, id:4'h6, len:4'h2, need_act:1'b0};
        vecs[6] = '{wr:1'b0, ra:16'h0056, ca:10'h010, id:4'h7, len:4'h4, need_act:1'b0};
        vecs[7] = '{wr:1'b1, ra:16'h0012, ca:10'h0c3, id:4'h8, len:4'h5, need_act:1'b1};

        tim.t_rcd_m1 = 8'(T_RCD); tim.t_ras_m1 = 8'(T_RAS); tim.t_rtp_m1 = 8'(T_RTP);
        tim.t_wtp_m1 = 8'(T_WTP); tim.t_rp_m1  = 8'(T_RP);  tim.t_rfc_m1 = 8'(T_RFC);
        tim.row_open_cnt = 8'(ROC_MAIN);
        req.valid = 1'b0; req.wr = 1'b0; req.ra = '0; req.ca = '0; req.id = '0; req.len = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_bits", 32'({sch.act_req, sch.rd_req, sch.wr_req, sch.pre_req, sch.ref_req}), 32'd0);
        check("rst_ready", 32'(req.ready), 32'd1);
        check("rst_ref_done", 32'(ref_done_o), 32'd0);
        check("rst_ra", 32'(sch.ra), 32'd0);
        check("rst_ca", 32'(sch.ca), 32'd0);
        check("rst_id", 32'(sch.id), 32'd0);
        check("rst_len", 32'(sch.len), 32'd0);
        check("rst_ba", 32'(sch.ba), 32'(BK));
        rst = 1'b0;
        tick();

        // first request: act_req one cycle after accept
        send(vecs[0]);
        check("accept_to_act", 32'(sch.act_req), 32'd1);
        for (int i = 1; i < 8; i++) send(vecs[i]);
        wait_sb_empty("table_drain", 300);
        repeat (40) tick();

        // idle timeout with pre grant withheld, then a hit withdraws it
        tim.row_open_cnt = 8'(ROC_IDLE);
        mask_pre = 1'b1;
        t = '{wr:1'b0, ra:16'h00ab, ca:10'h033, id:4'h9, len:4'h6, need_act:1'b1};
        send(t);
        wait_sb_empty("idle_rd_drain", 100);
        g = last_rd;
        a = last_act;
        n = 0;
        while (sch.pre_req !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        p = cyc;
        expd = g + ROC_IDLE + 1;
        if (a + T_RAS + 1 > expd) expd = a + T_RAS + 1;
        if (g + T_RTP + 1 > expd) expd = g + T_RTP + 1;
        check("idle_pre_cycle", 32'(p), 32'(expd));
        t = '{wr:1'b0, ra:16'h00ab, ca:10'h034, id:4'ha, len:4'h1, need_act:1'b0};
        send(t);
        check("hit_withdraws_pre", 32'(sch.pre_req), 32'd0);
        check("hit_gives_rd", 32'(sch.rd_req), 32'd1);
        mask_pre = 1'b0;
        wait_sb_empty("idle_hit_drain", 50);
        repeat (30) tick();

        // refresh while OPEN with a pending hit
        tim.row_open_cnt = 8'd200;
        mask_rd = 1'b1;
        t = '{wr:1'b0, ra:16'h0099, ca:10'h077, id:4'hb, len:4'h2, need_act:1'b1};
        send(t);
        n = 0;
        while (sch.rd_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ref_pending_rd", 32'(sch.rd_req), 32'd1);
        ref_req_i = 1'b1;
        mask_rd = 1'b0;
        n = 0;
        while (ref_done_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        x = cyc;
        ref_req_i = 1'b0;
        check("ref_done_seen", 32'(ref_done_o), 32'd1);
        check("ref_after_trp", 32'(last_ref - last_pre), 32'(T_RP + 1));
        check("ref_done_cycle", 32'(x - last_ref), 32'(T_RFC + 1));
        tick();
        check("ref_done_pulse", 32'(ref_done_o), 32'd0);
        wait_sb_empty("ref_drain", 50);
        check("act_after_ref", 32'(last_act), 32'(x + 1));
        tim.row_open_cnt = 8'(ROC_IDLE);
        repeat (30) tick();

        // withheld ACT grant with a spurious rd_gnt
        mask_act = 1'b1;
        t = '{wr:1'b0, ra:16'h0077, ca:10'h111, id:4'hc, len:4'h3, need_act:1'b1};
        send(t);
        spur_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold_act_req", 32'(sch.act_req), 32'd1);
            check("hold_ra", 32'(sch.ra), 32'h77);
            check("hold_ready", 32'(req.ready), 32'd0);
            check("hold_no_rd", 32'(sch.rd_req), 32'd0);
            tick();
        end
        spur_rd = 1'b0;
        check("hold_sb", 32'(sb.size()), 32'd1);
        mask_act = 1'b0;

        // asynchronous reset in the middle of tRCD
        n = 0;
        x = last_act;
        while (last_act == x && n < 20) begin
            tick();
            n++;
        end
        check("act_after_release", 32'(last_act != x), 32'd1);
        tick();
        #1;
        rst = 1'b1;
        #1;
        check("arst_req_bits", 32'({sch.act_req, sch.rd_req, sch.wr_req, sch.pre_req, sch.ref_req}), 32'd0);
        check("arst_ready", 32'(req.ready), 32'd1);
        check("arst_ra", 32'(sch.ra), 32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'({sch.act_req, sch.rd_req, sch.wr_req, sch.pre_req}), 32'd0);
        t = '{wr:1'b1, ra:16'h0078, ca:10'h222, id:4'hd, len:4'h4, need_act:1'b1};
        send(t);
        check("post_rst_act", 32'(sch.act_req), 32'd1);
        wait_sb_empty("post_rst_drain", 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
